gold_bag_controller: RTL and testbench
======================================

// Module: gold_bag_controller
// PURPOSE
//  Per-bag state machine that answers the collision detector: consumes per-pixel collision/eat
//  pulses plus a terrain-support pulse and produces the 4-bit bag state the detector decodes.
//  Collision inputs are latched per frame; state and position advance once per startOfFrame.
//  Drives bag position/visibility to the bag drawer and a score pulse to the score unit.
// PARAMETERS
//  INIT_X        320  bag top-left X (constant, pixels)
//  INIT_Y        96   bag top-left Y after reset (pixels)
//  FALL_SPEED    4    pixels moved per frame while falling
//  WOBBLE_FRAMES 30   frames of wobble before falling
//  BREAK_HEIGHT  32   fall distance (px) at or above which bag breaks into coins
//  FLOOR_Y       448  max top-left Y; reaching it counts as landing
//  COIN_LIFE     150  frames coins stay before vanishing
// PORTS
//  clk               in  1   system clock
//  resetN            in  1   async reset, active low
//  startOfFrame      in  1   1-cycle pulse, frame boundary
//  collision_gold_1  in  1   bag pixel overlaps player or alien (per-pixel pulse)
//  player_eat_gold_1 in  1   player overlaps bag while state==2 (per-pixel pulse)
//  gold_1_support    in  1   terrain pixel in 1-px strip directly under bag (per-pixel pulse)
//  gold_1_state      out 4   0 RESTING,1 FALLING,2 COINS,3 WOBBLE,4 COLLECTED
//  gold_1_topLeftX   out 11  = INIT_X
//  gold_1_topLeftY   out 11  current bag Y
//  gold_1_visible    out 1   0 only in COLLECTED
//  gold_1_score      out 1   1-cycle pulse when player collects coins
// BEHAVIOUR
//  Reset (async, resetN=0): state=RESTING, Y=INIT_Y, all counters 0, frame flags 0,
//   visible=1, score=0. Reset mid-fall/mid-wobble returns bag to INIT_Y at once.
//  Frame flags hit/eat/sup: set on any cycle their input is 1; on startOfFrame the FSM uses
//   flag|input (pulse on the SOF cycle belongs to the ending frame), then flags clear.
//  All transitions and Y updates happen only on the startOfFrame cycle; outputs are
//   registered, visible the cycle after SOF.
//  RESTING: !sup -> WOBBLE, wob_cnt=0. sup -> stay.
//  WOBBLE: sup -> RESTING (undermining undone); else wob_cnt++; when wob_cnt reaches
//   WOBBLE_FRAMES-1 -> FALLING, fall_dist=0.
//  FALLING: if sup or Y+FALL_SPEED>=FLOOR_Y: land (Y=min(Y,FLOOR_Y) when sup, else FLOOR_Y);
//   fall_dist>=BREAK_HEIGHT -> COINS, life=0; else -> RESTING.
//   Otherwise Y+=FALL_SPEED, fall_dist+=FALL_SPEED saturating at 255.
//  COINS: eat -> COLLECTED, score pulse 1 cycle (eat wins over hit same frame);
//   hit&!eat (alien) -> COLLECTED, no score; life reaches COIN_LIFE-1 -> COLLECTED, no score;
//   else life++.
//  COLLECTED: terminal until reset; visible=0; inputs ignored.
//  hit in RESTING/WOBBLE/FALLING ignored here (kill logic lives in the detector).
//  Widths: Y 11-bit unsigned; FLOOR_Y clamp prevents overflow; counters 8-bit.
//  States 5..15 unreachable; if entered, next SOF -> RESTING.
// TESTING
//  1 Reset, sup pulse every frame for 10 frames -> state 0, Y=96, visible 1.
//  2 Drop sup for 30 frames -> state 3 for 30 frames, then 1; Y steps 96,100,104...
//  3 Fall 8 frames then sup -> Y=128, dist 32 -> state 2; eat next frame -> state 4,
//    gold_1_score high exactly 1 cycle, visible 0.
//  4 Fall 4 frames then sup -> dist 16 -> state 0 at Y=112, no score.
//  5 COINS, eat and hit same frame -> state 4 + score; COINS with hit only -> 4, no score;
//    COINS idle 150 frames -> 4, no score.
//  6 Fall with no sup until floor -> Y clamps 448 -> state 2; resetN low mid-wobble ->
//    state 0, Y=96 immediately, no clock needed.

Source files
------------

// File: rtl/gold_bag_controller.sv
// Per-bag FSM: latches per-frame collision/eat/support pulses, advances state and Y once per startOfFrame.
// Latency: outputs registered, visible the cycle after startOfFrame; no backpressure, inputs always accepted.
module gold_bag_controller #(
  parameter int INIT_X        = 320,
  parameter int INIT_Y        = 96,
  parameter int FALL_SPEED    = 4,
  parameter int WOBBLE_FRAMES = 30,
  parameter int BREAK_HEIGHT  = 32,
  parameter int FLOOR_Y       = 448,
  parameter int COIN_LIFE     = 150
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        collision_gold_1,
  input  logic        player_eat_gold_1,
  input  logic        gold_1_support,
  output logic [3:0]  gold_1_state,
  output logic [10:0] gold_1_topLeftX,
  output logic [10:0] gold_1_topLeftY,
  output logic        gold_1_visible,
  output logic        gold_1_score
);

  typedef enum logic [3:0] {
    ST_RESTING   = 4'd0,
    ST_FALLING   = 4'd1,
    ST_COINS     = 4'd2,
    ST_WOBBLE    = 4'd3,
    ST_COLLECTED = 4'd4
  } state_t;

  state_t      state_q, state_n;
  logic [10:0] y_q, y_n;
  logic [7:0]  wob_q, wob_n;
  logic [7:0]  fall_q, fall_n;
  logic [7:0]  life_q, life_n;
  logic        hit_q, eat_q, sup_q;
  logic        score_q, score_n;
  logic        vis_q;
  logic        hit, eat, sup;
  logic [11:0] y_step;
  logic [8:0]  fall_sum;

  // A pulse on the SOF cycle itself still belongs to the frame that is ending.
  assign hit = hit_q | collision_gold_1;
  assign eat = eat_q | player_eat_gold_1;
  assign sup = sup_q | gold_1_support;

  assign y_step   = {1'b0, y_q} + 12'(FALL_SPEED);
  assign fall_sum = {1'b0, fall_q} + 9'(FALL_SPEED);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_RESTING;
      y_q     <= 11'(INIT_Y);
      wob_q   <= '0;
      fall_q  <= '0;
      life_q  <= '0;
      hit_q   <= 1'b0;
      eat_q   <= 1'b0;
      sup_q   <= 1'b0;
      score_q <= 1'b0;
      vis_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      y_q     <= y_n;
      wob_q   <= wob_n;
      fall_q  <= fall_n;
      life_q  <= life_n;
      score_q <= score_n;
      vis_q   <= (state_n != ST_COLLECTED);
      if (startOfFrame) begin
        hit_q <= 1'b0;
        eat_q <= 1'b0;
        sup_q <= 1'b0;
      end else begin
        hit_q <= hit;
        eat_q <= eat;
        sup_q <= sup;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    y_n     = y_q;
    wob_n   = wob_q;
    fall_n  = fall_q;
    life_n  = life_q;
    score_n = 1'b0;
    if (startOfFrame) begin
      case (state_q)
        ST_RESTING: begin
          if (!sup) begin
            state_n = ST_WOBBLE;
            wob_n   = '0;
          end
        end
        ST_WOBBLE: begin
          if (sup) begin
            state_n = ST_RESTING;
          end else if (wob_q == 8'(WOBBLE_FRAMES - 1)) begin
            state_n = ST_FALLING;
            fall_n  = '0;
          end else begin
            wob_n = wob_q + 8'd1;
          end
        end
        ST_FALLING: begin
          if (sup || (y_step >= 12'(FLOOR_Y))) begin
            if (!sup || (y_q > 11'(FLOOR_Y))) y_n = 11'(FLOOR_Y);
            if (fall_q >= 8'(BREAK_HEIGHT)) begin
              state_n = ST_COINS;
              life_n  = '0;
            end else begin
              state_n = ST_RESTING;
            end
          end else begin
            y_n    = y_step[10:0];
            fall_n = fall_sum[8] ? 8'hFF : fall_sum[7:0];
          end
        end
        ST_COINS: begin
          if (eat) begin
            state_n = ST_COLLECTED;
            score_n = 1'b1;
          end else if (hit || (life_q == 8'(COIN_LIFE - 1))) begin
            state_n = ST_COLLECTED;
          end else begin
            life_n = life_q + 8'd1;
          end
        end
        ST_COLLECTED: begin
          state_n = ST_COLLECTED;
        end
        default: begin
          state_n = ST_RESTING;
        end
      endcase
    end
  end

  assign gold_1_state    = state_q;
  assign gold_1_topLeftX = 11'(INIT_X);
  assign gold_1_topLeftY = y_q;
  assign gold_1_visible  = vis_q;
  assign gold_1_score    = score_q;

endmodule

// File: tb/tb_gold_bag_controller.sv
// Bench for gold_bag_controller: directed scenarios plus random frames, checked against a frame-level model.
module tb_gold_bag_controller;

  localparam int INIT_X        = 320;
  localparam int INIT_Y        = 96;
  localparam int FALL_SPEED    = 4;
  localparam int WOBBLE_FRAMES = 30;
  localparam int BREAK_HEIGHT  = 32;
  localparam int FLOOR_Y       = 448;
  localparam int COIN_LIFE     = 150;

  localparam int M_REST = 0, M_FALL = 1, M_COINS = 2, M_WOB = 3, M_DONE = 4;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        collision_gold_1;
  logic        player_eat_gold_1;
  logic        gold_1_support;
  logic [3:0]  gold_1_state;
  logic [10:0] gold_1_topLeftX;
  logic [10:0] gold_1_topLeftY;
  logic        gold_1_visible;
  logic        gold_1_score;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference: one update per completed frame, using frame counts.
  int m_state, m_y, m_fall_px, m_frames;
  bit m_score;

  gold_bag_controller dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .collision_gold_1  (collision_gold_1),
    .player_eat_gold_1 (player_eat_gold_1),
    .gold_1_support    (gold_1_support),
    .gold_1_state      (gold_1_state),
    .gold_1_topLeftX   (gold_1_topLeftX),
    .gold_1_topLeftY   (gold_1_topLeftY),
    .gold_1_visible    (gold_1_visible),
    .gold_1_score      (gold_1_score)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = M_REST;
    m_y       = INIT_Y;
    m_fall_px = 0;
    m_frames  = 0;
    m_score   = 1'b0;
  endtask

  task automatic model_frame(input bit sup, input bit eat, input bit hit);
    m_score = 1'b0;
    case (m_state)
      M_REST: if (!sup) begin m_state = M_WOB; m_frames = 0; end
      M_WOB: begin
        if (sup) m_state = M_REST;
        else begin
          m_frames++;
          if (m_frames == WOBBLE_FRAMES) begin m_state = M_FALL; m_fall_px = 0; end
        end
      end
      M_FALL: begin
        if (sup || m_y + FALL_SPEED >= FLOOR_Y) begin
          m_y      = sup ? ((m_y < FLOOR_Y) ? m_y : FLOOR_Y) : FLOOR_Y;
          m_state  = (m_fall_px >= BREAK_HEIGHT) ? M_COINS : M_REST;
          m_frames = 0;
        end else begin
          m_y       += FALL_SPEED;
          m_fall_px += FALL_SPEED;
        end
      end
      M_COINS: begin
        if (eat) begin m_state = M_DONE; m_score = 1'b1; end
        else if (hit) m_state = M_DONE;
        else begin
          m_frames++;
          if (m_frames == COIN_LIFE) m_state = M_DONE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic apply_reset();
    #1 resetN = 1'b0;
    #2;
    model_reset();
    chk("rst_state", gold_1_state, M_REST);
    chk("rst_y", gold_1_topLeftY, INIT_Y);
    chk("rst_visible", gold_1_visible, 1);
    chk("rst_score", gold_1_score, 0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  function automatic int pick(input int len);
    return ($urandom_range(0, 3) == 0) ? len : int'($urandom_range(0, len - 1));
  endfunction

  // One frame of random length; each requested pulse lands on one random cycle, sometimes the SOF cycle.
  task automatic do_frame(input bit sup, input bit eat, input bit hit);
    int len, ps, pe, ph;
    len = $urandom_range(2, 6);
    ps  = pick(len);
    pe  = pick(len);
    ph  = pick(len);
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      startOfFrame      = (c == len);
      gold_1_support    = sup && (c == ps);
      player_eat_gold_1 = eat && (c == pe);
      collision_gold_1  = hit && (c == ph);
    end
    @(negedge clk);
    startOfFrame      = 1'b0;
    gold_1_support    = 1'b0;
    player_eat_gold_1 = 1'b0;
    collision_gold_1  = 1'b0;
    model_frame(sup, eat, hit);
    chk("state", gold_1_state, m_state);
    chk("y", gold_1_topLeftY, m_y);
    chk("visible", gold_1_visible, (m_state != M_DONE) ? 1 : 0);
    chk("score", gold_1_score, m_score);
    @(negedge clk);
    chk("score_one_cycle", gold_1_score, 0);
  endtask

  task automatic fall_then_land(input int n);
    repeat (WOBBLE_FRAMES + 1 + n) do_frame(1'b0, 1'b0, 1'b0);
    do_frame(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    resetN            = 1'b1;
    startOfFrame      = 1'b0;
    collision_gold_1  = 1'b0;
    player_eat_gold_1 = 1'b0;
    gold_1_support    = 1'b0;
    model_reset();

    // Resting with support every frame
    apply_reset();
    chk("x_const", gold_1_topLeftX, INIT_X);
    repeat (10) do_frame(1'b1, 1'b0, 1'b0);
    chk("t1_state", gold_1_state, M_REST);
    chk("t1_y", gold_1_topLeftY, INIT_Y);

    // Wobble exactly WOBBLE_FRAMES frames, then fall 8 frames, land broken, eat
    repeat (WOBBLE_FRAMES) begin
      do_frame(1'b0, 1'b0, 1'b0);
      chk("t2_wobble", gold_1_state, M_WOB);
    end
    do_frame(1'b0, 1'b0, 1'b0);
    chk("t2_falling", gold_1_state, M_FALL);
    chk("t2_y_start", gold_1_topLeftY, 96);
    do_frame(1'b0, 1'b0, 1'b0);
    chk("t2_y_step", gold_1_topLeftY, 100);
    repeat (7) do_frame(1'b0, 1'b0, 1'b0);
    do_frame(1'b1, 1'b0, 1'b0);
    chk("t3_coins", gold_1_state, M_COINS);
    chk("t3_y", gold_1_topLeftY, 128);
    do_frame(1'b1, 1'b1, 1'b0);
    chk("t3_collected", gold_1_state, M_DONE);
    chk("t3_invisible", gold_1_visible, 0);
    do_frame(1'b0, 1'b1, 1'b1);
    chk("t3_terminal", gold_1_state, M_DONE);

    // Short fall lands intact
    apply_reset();
    fall_then_land(4);
    chk("t4_state", gold_1_state, M_REST);
    chk("t4_y", gold_1_topLeftY, 112);

    // Coins: eat+hit, hit only, timeout
    fall_then_land(8);
    chk("t5_coins_a", gold_1_state, M_COINS);
    do_frame(1'b1, 1'b1, 1'b1);
    chk("t5_eat_hit", gold_1_state, M_DONE);
    apply_reset();
    fall_then_land(8);
    do_frame(1'b1, 1'b0, 1'b1);
    chk("t5_hit_only", gold_1_state, M_DONE);
    apply_reset();
    fall_then_land(8);
    repeat (COIN_LIFE - 1) do_frame(1'b1, 1'b0, 1'b0);
    chk("t5_life_last", gold_1_state, M_COINS);
    do_frame(1'b1, 1'b0, 1'b0);
    chk("t5_timeout", gold_1_state, M_DONE);

    // Fall to the floor unsupported
    apply_reset();
    repeat (WOBBLE_FRAMES + 1) do_frame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200 && m_state == M_FALL; i++) do_frame(1'b0, 1'b0, 1'b0);
    chk("t6_floor_state", gold_1_state, M_COINS);
    chk("t6_floor_y", gold_1_topLeftY, FLOOR_Y);

    // Asynchronous reset mid-fall and mid-wobble
    apply_reset();
    repeat (WOBBLE_FRAMES + 6) do_frame(1'b0, 1'b0, 1'b0);
    chk("t6_midfall_y", gold_1_topLeftY, 116);
    apply_reset();
    repeat (10) do_frame(1'b0, 1'b0, 1'b0);
    chk("t6_midwobble", gold_1_state, M_WOB);
    apply_reset();

    // Random frames, biased per state so every path gets visited
    for (int f = 0; f < 400; f++) begin
      bit s, e, h;
      if (m_state == M_DONE) apply_reset();
      case (m_state)
        M_REST:  s = ($urandom_range(0, 99) < 80);
        M_WOB:   s = ($urandom_range(0, 99) < 3);
        M_FALL:  s = ($urandom_range(0, 99) < 10);
        default: s = $urandom_range(0, 1) == 1;
      endcase
      e = ($urandom_range(0, 99) < 3);
      h = ($urandom_range(0, 99) < 3);
      do_frame(s, e, h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
